// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side consumer for the async FIFO.
// Pops words from the FIFO read port into a 2-entry registered skid buffer and
// presents them as a valid/ready stream. Also supports flush and keeps a count
// of delivered words.
//
// Ports:
//   clk, reset        read-domain clock, async active-high reset
//   enable            permit new FIFO pops
//   flush             discard buffered words and drain the FIFO
//   fifo_empty        FIFO empty flag
//   fifo_read_data    FIFO head word
//   fifo_read_enable  FIFO pop strobe
//   stream_data       stream payload (buffer head)
//   stream_valid      stream payload valid
//   stream_ready      downstream ready
//   occupancy         buffered word count (0..2)
//   words_delivered   completed stream transfers, wrapping
//   busy              buffer or FIFO still holds data
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  output logic                   fifo_read_enable,
  output logic [DATA_WIDTH-1:0]  stream_data,
  output logic                   stream_valid,
  input  logic                   stream_ready,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] words_delivered,
  output logic                   busy
);

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;

  occ_t                   state, state_n;
  logic [DATA_WIDTH-1:0]  entry0, entry0_n;
  logic [DATA_WIDTH-1:0]  entry1, entry1_n;
  logic [COUNT_WIDTH-1:0] count, count_n;
  logic                   pop;
  logic                   transfer;

  // Pop strobe depends only on registered occupancy, never on stream_ready.
  assign fifo_read_enable = !reset && (flush ? !fifo_empty
                                             : (enable && !fifo_empty && (state != OCC_2)));
  assign pop              = fifo_read_enable && !fifo_empty;
  assign stream_valid     = !flush && (state != OCC_0);
  assign transfer         = stream_valid && stream_ready;
  assign stream_data      = entry0;
  assign occupancy        = state;
  assign words_delivered  = count;
  assign busy             = (state != OCC_0) || !fifo_empty;

  // State and buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= OCC_0;
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      entry0 <= entry0_n;
      entry1 <= entry1_n;
      count  <= count_n;
    end
  end

  // Skid buffer next-state: entry0 is always the stream head.
  always_comb begin
    state_n  = state;
    entry0_n = entry0;
    entry1_n = entry1;
    count_n  = count + COUNT_WIDTH'(transfer);
    if (flush) begin
      // Popped words are dropped; the buffer empties at this edge.
      state_n = OCC_0;
    end else begin
      unique case (state)
        OCC_0: begin
          if (pop) begin
            entry0_n = fifo_read_data;
            state_n  = OCC_1;
          end
        end
        OCC_1: begin
          if (pop && transfer) begin
            entry0_n = fifo_read_data;
          end else if (pop) begin
            entry1_n = fifo_read_data;
            state_n  = OCC_2;
          end else if (transfer) begin
            state_n  = OCC_0;
          end
        end
        OCC_2: begin
          if (transfer) begin
            entry0_n = entry1;
            state_n  = OCC_1;
          end
        end
        default: state_n = OCC_0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: behavioural FIFO model feeding the DUT,
// directed scenarios with hand-computed expectations.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data;
  logic          fifo_read_enable;
  logic [DW-1:0] stream_data;
  logic          stream_valid;
  logic          stream_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] words_delivered;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  // FIFO model
  logic [DW-1:0] mem [64];
  int wp = 0;
  int rp = 0;
  int pops = 0;
  logic [DW-1:0] rx [$];

  assign fifo_empty     = (wp == rp);
  assign fifo_read_data = mem[rp[5:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_read_enable && !fifo_empty) begin
      rp   <= rp + 1;
      pops <= pops + 1;
    end
    if (!reset && stream_valid && stream_ready) rx.push_back(stream_data);
  end

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_enable(fifo_read_enable), .stream_data(stream_data),
    .stream_valid(stream_valid), .stream_ready(stream_ready),
    .occupancy(occupancy), .words_delivered(words_delivered), .busy(busy)
  );

  task automatic push(input logic [DW-1:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp [3] = '{8'hA1, 8'hA2, 8'hA3};
    bit ok;
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (3) @(negedge clk);
    n_checks++; if (stream_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", stream_valid); else n_pass++;
    n_checks++; if (fifo_read_enable !== 1'b0) $display("FAIL rst_fre got %b exp 0", fifo_read_enable); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL rst_occ got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (words_delivered !== '0) $display("FAIL rst_cnt got %0d exp 0", words_delivered); else n_pass++;
    n_checks++; if (stream_data !== '0) $display("FAIL rst_data got %h exp 00", stream_data); else n_pass++;
    n_checks++; if (pops !== 0) $display("FAIL rst_pops got %0d exp 0", pops); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (fifo_read_enable !== 1'b1) $display("FAIL rel_fre got %b exp 1", fifo_read_enable); else n_pass++;
    @(negedge clk);
    n_checks++; if (pops !== 1) $display("FAIL rel_pops got %0d exp 1", pops); else n_pass++;
    n_checks++; if (stream_valid !== 1'b1 || stream_data !== 8'hA1)
      $display("FAIL rel_first got v=%b d=%h exp v=1 d=a1", stream_valid, stream_data); else n_pass++;
    n_checks++; if (occupancy !== 2'd1) $display("FAIL rel_occ got %0d exp 1", occupancy); else n_pass++;
    stream_ready = 1'b1;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL rst_drain_timeout got busy exp idle"); else n_pass++;
    exp_cnt += 3;
    n_checks++; if (rx.size() !== 3) $display("FAIL rst_rx_size got %0d exp 3", rx.size()); else n_pass++;
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      n_checks++; if (rx[i] !== exp[i]) $display("FAIL rst_rx[%0d] got %h exp %h", i, rx[i], exp[i]); else n_pass++;
    end
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL rst_cnt_end got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx.delete();
    stream_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(exp[i]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (stream_valid !== 1'b1 || stream_data !== exp[k])
        $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", k, stream_valid, stream_data, exp[k]); else n_pass++;
    end
    @(negedge clk);
    exp_cnt += 4;
    n_checks++; if (stream_valid !== 1'b0) $display("FAIL stream_end_valid got %b exp 0", stream_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL stream_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL stream_cnt got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int p0;
    bit ok;
    rx.delete();
    stream_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 4; i++) push(exp[i]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (stream_valid !== 1'b1 || stream_data !== 8'h11)
        $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=11", k, stream_valid, stream_data); else n_pass++;
    end
    n_checks++; if (occupancy !== 2'd2) $display("FAIL bp_occ got %0d exp 2", occupancy); else n_pass++;
    n_checks++; if (pops - p0 !== 2) $display("FAIL bp_pops got %0d exp 2", pops - p0); else n_pass++;
    n_checks++; if (fifo_read_enable !== 1'b0) $display("FAIL bp_fre got %b exp 0", fifo_read_enable); else n_pass++;
    stream_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (stream_valid !== 1'b1 || stream_data !== exp[k])
        $display("FAIL bp_b2b%0d got v=%b d=%h exp v=1 d=%h", k, stream_valid, stream_data, exp[k]); else n_pass++;
    end
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL bp_drain_timeout got busy exp idle"); else n_pass++;
    exp_cnt += 4;
    n_checks++; if (rx.size() !== 4) $display("FAIL bp_rx_size got %0d exp 4", rx.size()); else n_pass++;
    for (int i = 0; i < 4 && i < rx.size(); i++) begin
      n_checks++; if (rx[i] !== exp[i]) $display("FAIL bp_rx[%0d] got %h exp %h", i, rx[i], exp[i]); else n_pass++;
    end
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL bp_cnt got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_alternating();
    logic a, b;
    rx.delete();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      stream_ready = k[0];
      #1 a = fifo_read_enable;
      stream_ready = ~k[0];
      #1 b = fifo_read_enable;
      stream_ready = k[0];
      n_checks++; if (a !== b) $display("FAIL alt_fre_indep%0d got %b exp %b", k, b, a); else n_pass++;
    end
    stream_ready = 1'b1;
    @(negedge clk);
    exp_cnt += 8;
    n_checks++; if (busy !== 1'b0) $display("FAIL alt_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (rx.size() !== 8) $display("FAIL alt_rx_size got %0d exp 8", rx.size()); else n_pass++;
    for (int i = 0; i < 8 && i < rx.size(); i++) begin
      n_checks++; if (rx[i] !== DW'(i + 1)) $display("FAIL alt_rx[%0d] got %h exp %h", i, rx[i], DW'(i + 1)); else n_pass++;
    end
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL alt_cnt got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_flush();
    int p0;
    bit ok;
    rx.delete();
    stream_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) push(DW'(8'hB0 + i));
    repeat (4) @(negedge clk);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL fl_pre_occ got %0d exp 2", occupancy); else n_pass++;
    n_checks++; if (pops - p0 !== 2) $display("FAIL fl_pre_pops got %0d exp 2", pops - p0); else n_pass++;
    flush = 1'b1;
    stream_ready = 1'b1;
    #1;
    n_checks++; if (stream_valid !== 1'b0) $display("FAIL fl_valid got %b exp 0", stream_valid); else n_pass++;
    n_checks++; if (fifo_read_enable !== 1'b1) $display("FAIL fl_fre got %b exp 1", fifo_read_enable); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (stream_valid !== 1'b0) $display("FAIL fl_valid%0d got %b exp 0", k, stream_valid); else n_pass++;
    end
    n_checks++; if (pops - p0 !== 5) $display("FAIL fl_pops got %0d exp 5", pops - p0); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL fl_occ got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL fl_cnt got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
    n_checks++; if (rx.size() !== 0) $display("FAIL fl_rx_size got %0d exp 0", rx.size()); else n_pass++;
    flush = 1'b0;
    push(8'hA5);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL fl_drain_timeout got busy exp idle"); else n_pass++;
    exp_cnt += 1;
    n_checks++; if (rx.size() !== 1 || rx[0] !== 8'hA5)
      $display("FAIL fl_after got n=%0d d=%h exp n=1 d=a5", rx.size(), (rx.size() > 0) ? rx[0] : 8'h00); else n_pass++;
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL fl_cnt_after got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    rx.delete();
    stream_ready = 1'b1;
    for (int i = 0; i < 11; i++) push(DW'(8'h60 + i));
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL wrap_fill_timeout got busy exp idle"); else n_pass++;
    exp_cnt += 11;
    n_checks++; if (words_delivered !== 4'd15) $display("FAIL wrap_pre got %0d exp 15", words_delivered); else n_pass++;
    push(8'hC1); push(8'hC2);
    @(negedge clk);
    n_checks++; if (words_delivered !== 4'd15) $display("FAIL wrap_15 got %0d exp 15", words_delivered); else n_pass++;
    @(negedge clk);
    n_checks++; if (words_delivered !== 4'd0) $display("FAIL wrap_0 got %0d exp 0", words_delivered); else n_pass++;
    @(negedge clk);
    n_checks++; if (words_delivered !== 4'd1) $display("FAIL wrap_1 got %0d exp 1", words_delivered); else n_pass++;
    exp_cnt += 2;
  endtask

  task automatic test_enable_off();
    int p0;
    bit ok;
    rx.delete();
    stream_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 4; i++) push(DW'(8'hD0 + i));
    repeat (3) @(negedge clk);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL en_pre_occ got %0d exp 2", occupancy); else n_pass++;
    enable = 1'b0;
    #1;
    n_checks++; if (fifo_read_enable !== 1'b0) $display("FAIL en_fre got %b exp 0", fifo_read_enable); else n_pass++;
    stream_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (pops - p0 !== 2) $display("FAIL en_pops got %0d exp 2", pops - p0); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL en_occ got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL en_busy got %b exp 1", busy); else n_pass++;
    n_checks++; if (rx.size() !== 2) $display("FAIL en_rx_size got %0d exp 2", rx.size()); else n_pass++;
    for (int i = 0; i < 2 && i < rx.size(); i++) begin
      n_checks++; if (rx[i] !== DW'(8'hD1 + i)) $display("FAIL en_rx[%0d] got %h exp %h", i, rx[i], DW'(8'hD1 + i)); else n_pass++;
    end
    exp_cnt += 2;
    n_checks++; if (words_delivered !== CW'(exp_cnt)) $display("FAIL en_cnt got %0d exp %0d", words_delivered, CW'(exp_cnt)); else n_pass++;
    enable = 1'b1;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL en_drain_timeout got busy exp idle"); else n_pass++;
    exp_cnt += 2;
    n_checks++; if (rx.size() !== 4 || rx[rx.size()-1] !== 8'hD4)
      $display("FAIL en_resume got n=%0d exp n=4 last=d4", rx.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    stream_ready = 1'b0;
    push(8'hE1); push(8'hE2);
    repeat (2) @(negedge clk);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL ar_pre_occ got %0d exp 2", occupancy); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL ar_occ got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (stream_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", stream_valid); else n_pass++;
    n_checks++; if (stream_data !== '0) $display("FAIL ar_data got %h exp 00", stream_data); else n_pass++;
    n_checks++; if (words_delivered !== '0) $display("FAIL ar_cnt got %0d exp 0", words_delivered); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL ar_busy got %b exp 0", busy); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    flush = 1'b0;
    stream_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_alternating();
    test_flush();
    test_wrap();
    test_enable_off();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the async FIFO. Runs on the FIFO's read clock domain, pops words through the FIFO's read_enable/empty/read_data interface and presents them as a valid/ready stream.
- A 2-entry registered output buffer (skid) sustains one word per cycle. fifo_read_enable never depends combinationally on stream_ready.
- Also provides flush (discard) and a delivered-word counter for the analyser's capture path.

Parameters:
- DATA_WIDTH, 8: width of FIFO words and stream data.
- COUNT_WIDTH, 16: width of the delivered-word counter.

Ports:
- clk  input  1  read-domain clock, the FIFO's read_clk.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits new pops from the FIFO. Words already buffered are still delivered while low.
- flush  input  1  synchronous. Discards buffered words and drains the FIFO while high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_data  input  DATA_WIDTH  FIFO head word. Valid combinationally in the same cycle while fifo_empty=0.
- fifo_read_enable  output  1  pop strobe. The FIFO advances at the clk edge when high and fifo_empty=0.
- stream_data  output  DATA_WIDTH  head of the output buffer.
- stream_valid  output  1  stream_data holds a word.
- stream_ready  input  1  downstream accepts the word.
- occupancy  output  2  buffered word count, 0..2.
- words_delivered  output  COUNT_WIDTH  count of completed stream transfers. Wraps modulo 2^COUNT_WIDTH.
- busy  output  1  occupancy!=0 or fifo_empty=0.

Behaviour:
- Reset (async assert, released synchronously by the system): occupancy=0, stream_valid=0, stream_data=0, both buffer entries=0, words_delivered=0. fifo_read_enable=0 for as long as reset is high.
- Definitions:
  - transfer = stream_valid & stream_ready.
  - pop = fifo_read_enable & !fifo_empty.
- Normal mode (flush=0):
  - fifo_read_enable = enable & !fifo_empty & (occupancy<2). It is a function of registered occupancy only, never of stream_ready.
  - stream_valid = (occupancy!=0). stream_data = entry0, a register with no combinational path from fifo_read_data.
- Occupancy/entry update at each clk edge:
  - occ 0, pop: entry0<=fifo_read_data, occ->1.
  - occ 1, pop & transfer: entry0<=fifo_read_data, occ stays 1. This is full throughput.
  - occ 1, pop & !transfer: entry1<=fifo_read_data, occ->2.
  - occ 1, !pop & transfer: occ->0.
  - occ 2, transfer: entry0<=entry1, occ->1. No pop is possible at occ 2.
  - Any other combination: hold.
- Latency: a word that is FIFO head with occupancy=0 appears with stream_valid=1 on the cycle after the pop edge (1 cycle).
- Ordering: strictly FIFO order. No word is duplicated or dropped outside flush.
- stream_data and stream_valid are stable while stream_valid=1 and stream_ready=0, per the standard valid/ready rule.
- words_delivered increments by 1 on every transfer edge. It wraps from 2^COUNT_WIDTH-1 to 0. It is not cleared by flush.
- enable=0: no pops. The buffer keeps draining to downstream. A pop already committed at an edge completes normally.
- Flush mode (flush=1):
  - stream_valid forced 0, so no transfer and no count.
  - fifo_read_enable = !fifo_empty, regardless of enable. Popped data is discarded.
  - occupancy->0 at the edge.
  - After flush deasserts, normal operation resumes from the next cycle with an empty buffer.
- busy=0 exactly when both the buffer and the FIFO are empty, i.e. the stream is fully drained.
- Reset mid-operation: buffered words are lost and outputs take reset values immediately (asynchronous).

Test Plan:
- Reset with FIFO holding 3 words -> stream_valid=0, fifo_read_enable=0, occupancy=0, words_delivered=0 during reset. The first pop occurs on the first edge after release.
- Write 0x11,0x22,0x33,0x44, stream_ready=1 throughout -> stream_valid continuous for 4 cycles starting 1 cycle after the first pop. Data 0x11,0x22,0x33,0x44 in order. words_delivered=4. busy=0 afterwards.
- 4 words queued, stream_ready=0 for 5 cycles -> occupancy settles at 2 with exactly 2 pops, fifo_read_enable=0 thereafter, stream_data held at 0x11. On ready=1 the words arrive back-to-back in order.
- Alternating stream_ready 1/0 over 8 queued words (0x01..0x08) -> no loss or duplication. fifo_read_enable never changes within a cycle in response to stream_ready.
- Buffer at occ=2 plus 3 words in FIFO, flush=1 for 4 cycles -> stream_valid=0, all 3 FIFO words popped, occupancy=0, words_delivered unchanged. A new word 0xA5 is delivered after flush drops.
- words_delivered preset near wrap (COUNT_WIDTH=4, 15 transfers done) plus 2 transfers -> count reads 15, then 0, then 1. enable=0 with 2 buffered words -> both delivered, no further pops.
